// File: rtl/ring_phase_checker.sv
// ring_phase_checker: registers a one-hot ring counter output and checks it stays one-hot and rotates in DIR,
// tracking lock status, phase index, revolutions and lock-loss errors.
module ring_phase_checker #(
  parameter int N        = 4,
  parameter int PW       = 2,
  parameter int DIR      = 0,
  parameter int LOCK_LEN = 4,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  din,
  output logic [PW-1:0] phase,
  output logic          locked,
  output logic          rev_tick,
  output logic [CW-1:0] rev_count,
  output logic          err,
  output logic [7:0]    err_count
);
  typedef enum logic [1:0] {SYNC, TRACK, LOCKED} state_t;
  localparam logic [PW-1:0] WRAP = (DIR != 0) ? PW'(N - 1) : '0;
  state_t        r_state, w_state;
  logic [N-1:0]  r_din_q, r_ref, w_ref, w_exp;
  logic [3:0]    r_cnt, w_cnt;
  logic [PW-1:0] r_phase, w_phase, w_idx;
  logic          r_locked, w_locked, r_tick, w_tick, r_err, w_err;
  logic [CW-1:0] r_rc, w_rc;
  logic [7:0]    r_ec, w_ec;
  logic          w_onehot, w_match, w_accept;
  assign w_exp    = (DIR != 0) ? {r_ref[0], r_ref[N-1:1]} : {r_ref[N-2:0], r_ref[N-1]};
  assign w_onehot = $onehot(r_din_q);
  assign w_match  = r_din_q == w_exp;
  assign w_ref    = w_accept ? r_din_q : r_ref;
  assign w_phase  = w_accept ? w_idx : r_phase;
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N; i++)
      if (r_din_q[i]) w_idx = PW'(i);
  end
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_locked = r_locked;
    w_tick   = 1'b0;
    w_rc     = r_rc;
    w_err    = r_err;
    w_ec     = r_ec;
    w_accept = 1'b0;
    case (r_state)
      SYNC: begin
        w_accept = w_onehot;
        w_cnt    = '0;
        w_state  = w_onehot ? TRACK : SYNC;
      end
      TRACK: begin
        w_accept = w_onehot;
        w_cnt    = w_match ? r_cnt + 4'd1 : '0;
        w_state  = !w_onehot ? SYNC : (w_match && w_cnt == 4'(LOCK_LEN)) ? LOCKED : TRACK;
        w_locked = w_state == LOCKED;
      end
      LOCKED: begin
        w_accept = w_onehot;
        w_tick   = w_match && w_idx == WRAP;
        w_rc     = r_rc + CW'(w_tick);
        w_locked = w_match;
        w_err    = r_err | !w_match;
        w_ec     = r_ec + {7'd0, !w_match && r_ec != 8'hFF};
        w_cnt    = w_match ? r_cnt : '0;
        w_state  = w_match ? LOCKED : w_onehot ? TRACK : SYNC;
      end
      default: w_state = SYNC;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SYNC;
      r_din_q  <= '0;
      r_ref    <= '0;
      r_cnt    <= '0;
      r_phase  <= '0;
      r_locked <= 1'b0;
      r_tick   <= 1'b0;
      r_rc     <= '0;
      r_err    <= 1'b0;
      r_ec     <= '0;
    end else begin
      r_state  <= w_state;
      r_din_q  <= din;
      r_ref    <= w_ref;
      r_cnt    <= w_cnt;
      r_phase  <= w_phase;
      r_locked <= w_locked;
      r_tick   <= w_tick;
      r_rc     <= w_rc;
      r_err    <= w_err;
      r_ec     <= w_ec;
    end
  end
  assign phase     = r_phase;
  assign locked    = r_locked;
  assign rev_tick  = r_tick;
  assign rev_count = r_rc;
  assign err       = r_err;
  assign err_count = r_ec;
endmodule

// File: tb/tb_ring_phase_checker.sv
// tb_ring_phase_checker: directed scenarios for ring_phase_checker (N=4, DIR=0, LOCK_LEN=4),
// with a transaction-level reference model feeding a scoreboard queue of expected outputs.
module tb_ring_phase_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  din = 4'b0000;
  logic [1:0]  phase;
  logic        locked, rev_tick, err;
  logic [15:0] rev_count;
  logic [7:0]  err_count;
  ring_phase_checker #(.N(4), .PW(2), .DIR(0), .LOCK_LEN(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .din(din), .phase(phase), .locked(locked), .rev_tick(rev_tick),
    .rev_count(rev_count), .err(err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [1:0]  ph;
    logic        lk;
    logic        tk;
    logic [15:0] rc;
    logic        er;
    logic [7:0]  ec;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int pos = 0;
  // reference model: m_st 0=sync 1=track 2=locked; m_dq is the sample awaiting evaluation
  logic [3:0]  m_dq, m_ref;
  int          m_st, m_cnt;
  exp_t        m;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  function automatic logic [3:0] rotl(input logic [3:0] x);
    return ((x << 1) | (x >> 3)) & 4'hF;
  endfunction
  task automatic take();
    m_ref = m_dq;
    m.ph  = 2'($clog2(m_dq));
  endtask
  task automatic mstep(input logic [3:0] d, input logic r);
    logic oh, eq;
    m.tk = 1'b0;
    if (r) begin
      m = '0;
      m_dq = 4'b0000; m_ref = 4'b0000; m_st = 0; m_cnt = 0;
    end else begin
      oh = $countones(m_dq) == 1;
      eq = m_dq == rotl(m_ref);
      if (m_st == 0) begin
        if (oh) begin take(); m_cnt = 0; m_st = 1; end
      end else if (m_st == 1) begin
        if (eq) begin
          take(); m_cnt++;
          if (m_cnt == 4) begin m_st = 2; m.lk = 1'b1; end
        end else if (oh) begin take(); m_cnt = 0; end
        else begin m_st = 0; m_cnt = 0; end
      end else if (eq) begin
        take();
        if (m.ph == 2'd0) begin m.tk = 1'b1; m.rc = m.rc + 16'd1; end
      end else begin
        m.lk = 1'b0; m.er = 1'b1; m_cnt = 0;
        if (m.ec != 8'd255) m.ec = m.ec + 8'd1;
        if (oh) begin take(); m_st = 1; end else m_st = 0;
      end
      m_dq = d;
    end
  endtask
  task automatic cyc(input logic [3:0] d, input logic r);
    exp_t e;
    @(negedge clk);
    din = d; rst = r;
    mstep(d, r);
    q.push_back(m);
    @(posedge clk); #1;
    e = q.pop_front();
    chk("phase", 32'(phase), 32'(e.ph));
    chk("locked", 32'(locked), 32'(e.lk));
    chk("rev_tick", 32'(rev_tick), 32'(e.tk));
    chk("rev_count", 32'(rev_count), 32'(e.rc));
    chk("err", 32'(err), 32'(e.er));
    chk("err_count", 32'(err_count), 32'(e.ec));
  endtask
  task automatic rot(input int n);
    logic [3:0] one;
    one = 4'b0001;
    repeat (n) begin
      cyc(one << pos, 1'b0);
      pos = (pos + 1) % 4;
    end
  endtask
  task automatic glitch();
    cyc(4'b0110, 1'b0);
    pos = (pos + 1) % 4;
  endtask
  initial begin
    m = '0; m_dq = '0; m_ref = '0; m_st = 0; m_cnt = 0;
    // 1: reset with a non-one-hot input
    cyc(4'b0101, 1'b1);
    chk("rst_err_count", 32'(err_count), 32'd0);
    cyc(4'b0101, 1'b1);
    // 2: clean lock, then 10 full revolutions
    pos = 0;
    rot(5);
    chk("lock_not_yet", 32'(locked), 32'd0);
    rot(1);
    chk("lock_rise", 32'(locked), 32'd1);
    chk("lock_phase", 32'(phase), 32'd0);
    rot(40);
    chk("rev10", 32'(rev_count), 32'd10);
    chk("rev10_err", 32'(err), 32'd0);
    // 3: glitch replacing a 0100 sample
    chk("glitch_slot", 32'(pos), 32'd2);
    glitch();
    rot(1);
    chk("glitch_locked", 32'(locked), 32'd0);
    chk("glitch_err", 32'(err), 32'd1);
    chk("glitch_ec", 32'(err_count), 32'd1);
    rot(5);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_err", 32'(err), 32'd1);
    // 4: stuck ring
    cyc(4'b0001, 1'b1);
    repeat (20) cyc(4'b0001, 1'b0);
    chk("stuck_locked", 32'(locked), 32'd0);
    chk("stuck_phase", 32'(phase), 32'd0);
    chk("stuck_err", 32'(err), 32'd0);
    // 5: all-zero input, then clean rotation
    cyc(4'b0000, 1'b1);
    repeat (8) cyc(4'b0000, 1'b0);
    pos = 0;
    rot(6);
    chk("zero_then_lock", 32'(locked), 32'd1);
    // 6: saturation of the error counter, then reset mid-lock
    repeat (300) begin
      glitch();
      rot(7);
    end
    chk("ec_sat", 32'(err_count), 32'd255);
    chk("sat_locked", 32'(locked), 32'd1);
    cyc(4'b0001, 1'b1);
    chk("midrst_rc", 32'(rev_count), 32'd0);
    chk("midrst_ec", 32'(err_count), 32'd0);
    rot(8);
    chk("post_rst_lock", 32'(locked), 32'd1);
    chk("post_rst_err", 32'(err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
